// File: rtl/dmem_req_pkg.sv
// Shared types and defaults for the data-memory request controller.
package dmem_req_pkg;

   localparam int unsigned ADDR_W_DEF  = 16;
   localparam int unsigned DATA_W_DEF  = 16;
   localparam int unsigned TIMEOUT_DEF = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ERR    = 2'd2
   } state_e;

   typedef enum logic {
      OP_LD = 1'b0,
      OP_ST = 1'b1
   } op_e;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up counter with synchronous clear that sticks at 16'hFFFF.
module sat_counter16 (
   input  logic        clk_i,
   input  logic        clr_i,
   input  logic        inc_i,
   output logic [15:0] cnt_o
);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_req_ctrl.sv
// Memory-stage request controller in front of the data cache.
// Define DMEM_REQ_STATS_EN to build the access/hit statistics counters.
module dmem_req_ctrl
   import dmem_req_pkg::*;
#(
   parameter int unsigned ADDR_W         = ADDR_W_DEF,
   parameter int unsigned DATA_W         = DATA_W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rd,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              err_sticky,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_data_in,
   output logic              dm_rd,
   output logic              dm_wr,
   input  logic [DATA_W-1:0] dm_data_out,
   input  logic              dm_done,
   input  logic              dm_stall,
   input  logic              dm_cache_hit,
   output logic [15:0]       stat_access,
   output logic [15:0]       stat_hit
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_e              state_q, state_d;
   op_e                 op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_err_q, resp_err_d;
   logic                sticky_q, sticky_d;
   logic                resp_acc_q, resp_acc_d;
   logic [15:0]         tmr_cnt;

   // Watchdog restarts from zero every time ACCESS is entered.
   sat_counter16 u_tmr (
      .clk_i (clk),
      .clr_i (rst || (state_q != ACCESS)),
      .inc_i ((state_q == ACCESS) && !dm_done),
      .cnt_o (tmr_cnt)
   );

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      sticky_d     = sticky_q;
      resp_acc_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && (req_rd || req_wr)) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               op_d    = (req_wr && !req_rd) ? OP_ST : OP_LD;
               if (req_addr[0] || (req_rd && req_wr)) begin
                  state_d = ERR;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            // dm_done wins over a watchdog expiry in the same cycle.
            if (dm_done) begin
               resp_valid_d = 1'b1;
               resp_acc_d   = 1'b1;
               rdata_d      = (op_q == OP_LD) ? dm_data_out : '0;
               state_d      = IDLE;
            end else if (tmr_cnt == TMO_LAST) begin
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               resp_acc_d   = 1'b1;
               rdata_d      = '0;
               sticky_d     = 1'b1;
               state_d      = IDLE;
            end
         end
         ERR: begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            rdata_d      = '0;
            sticky_d     = 1'b1;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         op_q         <= OP_LD;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         sticky_q     <= 1'b0;
         resp_acc_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         sticky_q     <= sticky_d;
         resp_acc_q   <= resp_acc_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign dm_rd      = (state_q == ACCESS) && (op_q == OP_LD);
   assign dm_wr      = (state_q == ACCESS) && (op_q == OP_ST);
   assign dm_addr    = addr_q;
   assign dm_data_in = wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = rdata_q;
   assign err_sticky = sticky_q;

`ifdef DMEM_REQ_STATS_EN
   logic stat_acc_inc, stat_hit_inc;
   logic unused_stall;

   // The cache's hit flag is valid in the response cycle, one after dm_done.
   assign stat_acc_inc = resp_valid_q && resp_acc_q;
   assign stat_hit_inc = stat_acc_inc && dm_cache_hit;
   assign unused_stall = dm_stall;

   sat_counter16 u_stat_access (
      .clk_i (clk),
      .clr_i (rst),
      .inc_i (stat_acc_inc),
      .cnt_o (stat_access)
   );

   sat_counter16 u_stat_hit (
      .clk_i (clk),
      .clr_i (rst),
      .inc_i (stat_hit_inc),
      .cnt_o (stat_hit)
   );
`else
   logic unused_inputs;

   assign stat_access   = '0;
   assign stat_hit      = '0;
   assign unused_inputs = ^{dm_stall, dm_cache_hit, resp_acc_q};
`endif

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Self-checking bench for dmem_req_ctrl: directed vector table, random requests
// against a behavioural cache/memory model, plus reset and idle sequences.
module tb_dmem_req_ctrl;

   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 16;
   localparam int unsigned TMO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_rd, req_wr;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          resp_valid, resp_err, err_sticky;
   logic [DW-1:0] resp_rdata;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_data_in, dm_data_out;
   logic          dm_rd, dm_wr, dm_done, dm_stall, dm_cache_hit;
   logic [15:0]   stat_access, stat_hit;

   always #5 clk = ~clk;

   dmem_req_ctrl #(
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_rd       (req_rd),
      .req_wr       (req_wr),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .err_sticky   (err_sticky),
      .dm_addr      (dm_addr),
      .dm_data_in   (dm_data_in),
      .dm_rd        (dm_rd),
      .dm_wr        (dm_wr),
      .dm_data_out  (dm_data_out),
      .dm_done      (dm_done),
      .dm_stall     (dm_stall),
      .dm_cache_hit (dm_cache_hit),
      .stat_access  (stat_access),
      .stat_hit     (stat_hit)
   );

   int unsigned passed = 0;
   int unsigned total  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Cache model: Done after cache_lat stall cycles (never if cache_never);
   // hit flag presented the cycle after Done.
   logic [15:0] cache_mem [0:255];
   logic [15:0] ref_mem   [0:255];
   int unsigned cache_lat = 0;
   bit          cache_never = 0;
   bit          cache_hit_flag = 0;
   int unsigned busy = 0;
   bit          done_prev = 0;
   bit          hit_latched = 0;

   always @(negedge clk) begin
      logic [AW-1:0] a;
      a = dm_addr;
      dm_cache_hit = done_prev & hit_latched;
      if (dm_rd || dm_wr) begin
         if (!cache_never && busy >= cache_lat) begin
            dm_done = 1'b1;
            hit_latched = cache_hit_flag;
            if (dm_wr) cache_mem[a[8:1]] = dm_data_in;
            dm_data_out = cache_mem[a[8:1]];
         end else begin
            dm_done = 1'b0;
            dm_data_out = DW'($urandom);
         end
         busy++;
      end else begin
         dm_done = 1'b0;
         busy = 0;
      end
      dm_stall = (dm_rd || dm_wr) && !dm_done;
      done_prev = dm_done;
   end

   bit          m_sticky = 0;
   int unsigned m_acc = 0;
   int unsigned m_hit = 0;

   function automatic void expect_of(input bit rd, input bit wr, input logic [AW-1:0] addr,
                                     input int unsigned lat, input bit never,
                                     output bit err, output int unsigned lat_exp);
      bit bad;
      bad = addr[0] || (rd && wr);
      err = bad || never;
      lat_exp = bad ? 2 : (never ? TMO + 1 : lat + 2);
   endfunction

   task automatic run_req(input bit rd, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int unsigned lat,
                          input bit never, input bit hit,
                          input bit exp_err, input int unsigned exp_lat);
      int unsigned n, active, stable_bad, ready_bad, exp_active;
      logic [DW-1:0] exp_rdata;
      bit bad;
      bad = addr[0] || (rd && wr);
      exp_active = bad ? 0 : exp_lat - 1;
      exp_rdata = (exp_err || wr) ? '0 : ref_mem[addr[8:1]];
      cache_lat = lat; cache_never = never; cache_hit_flag = hit;
      req_valid = 1'b1; req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
      req_addr = AW'($urandom); req_wdata = DW'($urandom);
      n = 1; active = 0; stable_bad = 0; ready_bad = 0;
      while (!resp_valid && n <= 300) begin
         if (dm_rd || dm_wr) begin
            active++;
            if (dm_addr !== addr || dm_data_in !== wdata || dm_rd !== rd || dm_wr !== wr)
               stable_bad++;
         end
         if (req_ready) ready_bad++;
         n++;
         @(negedge clk);
      end
      chk("latency", n, exp_lat);
      chk("resp_err", resp_err, exp_err);
      chk("resp_rdata", resp_rdata, exp_rdata);
      if (exp_err) m_sticky = 1;
      chk("err_sticky", err_sticky, m_sticky);
      chk("active_cycles", active, exp_active);
      chk("cache_req_stable", stable_bad, 0);
      chk("ready_low", ready_bad, 0);
      chk("req_dropped", {dm_rd, dm_wr}, 2'b00);
      if (!exp_err && wr) ref_mem[addr[8:1]] = wdata;
      if (!bad) m_acc++;
      if (!exp_err && hit) m_hit++;
   endtask

   task automatic chk_reset_state(input string name);
      chk({name, "_ctl"}, {req_ready, resp_valid, resp_err, err_sticky, dm_rd, dm_wr}, 6'b100000);
      chk({name, "_data"}, {dm_addr, dm_data_in, resp_rdata}, '0);
      chk({name, "_stats"}, {stat_access, stat_hit}, '0);
   endtask

   typedef struct {
      bit              rd, wr;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   wdata;
      int unsigned     lat;
      bit              never, hit;
      bit              exp_err;
      int unsigned     exp_lat;
   } vec_t;

   vec_t vecs [10];

   initial begin
      vecs[0] = '{1, 0, 16'h0010, 16'h0000, 0, 0, 1, 0, 2};      // load hit
      vecs[1] = '{0, 1, 16'h0124, 16'h5A5A, 6, 0, 0, 0, 8};      // store miss
      vecs[2] = '{1, 0, 16'h0124, 16'h0000, 1, 0, 0, 0, 3};      // load back
      vecs[3] = '{1, 0, 16'h0003, 16'h0000, 0, 0, 0, 1, 2};      // misaligned
      vecs[4] = '{1, 0, 16'h0020, 16'h0000, 0, 1, 0, 1, TMO + 1}; // timeout
      vecs[5] = '{1, 1, 16'h0030, 16'h1111, 0, 0, 0, 1, 2};      // rd & wr
      vecs[6] = '{1, 0, 16'h0040, 16'h0000, TMO - 1, 0, 0, 0, TMO + 1}; // done on last cycle
      vecs[7] = '{0, 1, 16'h0125, 16'h7777, 0, 0, 0, 1, 2};      // misaligned store
      vecs[8] = '{0, 1, 16'h0010, 16'h1234, 0, 0, 1, 0, 2};      // store hit
      vecs[9] = '{1, 0, 16'h0010, 16'h0000, 0, 0, 1, 0, 2};      // load hit after store

      for (int i = 0; i < 256; i++) begin
         logic [15:0] v;
         v = 16'($urandom);
         cache_mem[i] = v;
         ref_mem[i]   = v;
      end
      cache_mem[8'h08] = 16'hBEEF;
      ref_mem[8'h08]   = 16'hBEEF;

      rst = 1'b1; req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
      req_addr = '0; req_wdata = '0;
      @(negedge clk); @(negedge clk);
      chk_reset_state("reset");
      rst = 1'b0;
      @(negedge clk);

      chk("load_hit_data_pre", ref_mem[8'h08], 16'hBEEF);
      for (int i = 0; i < 10; i++)
         run_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat,
                 vecs[i].never, vecs[i].hit, vecs[i].exp_err, vecs[i].exp_lat);

      // Request with neither rd nor wr is ignored.
      begin
         int unsigned seen;
         seen = 0;
         req_valid = 1'b1; req_addr = 16'h0050;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid || dm_rd || dm_wr || !req_ready) seen++;
         end
         req_valid = 1'b0;
         chk("ignore_no_op", seen, 0);
      end

      for (int i = 0; i < 40; i++) begin
         bit rd, wr, never, err;
         int unsigned r, lat, exp_lat;
         logic [AW-1:0] addr;
         r = $urandom_range(0, 9);
         rd = (r == 0) || (r < 5);
         wr = (r == 0) || (r >= 5);
         addr = AW'($urandom_range(0, 511)) & ~AW'(1);
         if ($urandom_range(0, 7) == 0) addr = addr | AW'(1);
         never = ($urandom_range(0, 11) == 0);
         lat = $urandom_range(0, TMO - 1);
         expect_of(rd, wr, addr, lat, never, err, exp_lat);
         run_req(rd, wr, addr, DW'($urandom), lat, never, lat == 0, err, exp_lat);
      end

`ifdef DMEM_REQ_STATS_EN
      chk("stat_access_mid", stat_access, 16'(m_acc));
      chk("stat_hit_mid", stat_hit, 16'(m_hit));
`endif

      // Reset in the third cycle of a miss abandons the request.
      begin
         int unsigned seen;
         cache_lat = 20; cache_never = 0; cache_hit_flag = 0;
         req_valid = 1'b1; req_rd = 1'b1; req_wr = 1'b0; req_addr = 16'h0042;
         @(negedge clk);
         req_valid = 1'b0; req_rd = 1'b0;
         @(negedge clk); @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         chk_reset_state("mid_reset");
         m_sticky = 0; m_acc = 0; m_hit = 0;
         seen = 0;
         for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_valid || dm_rd) seen++;
         end
         chk("no_resp_after_reset", seen, 0);
      end

      // Stats scenario: three hits then one miss.
      run_req(1, 0, 16'h0060, 16'h0000, 0, 0, 1, 0, 2);
      run_req(0, 1, 16'h0062, 16'hA5A5, 0, 0, 1, 0, 2);
      run_req(1, 0, 16'h0062, 16'h0000, 0, 0, 1, 0, 2);
      run_req(1, 0, 16'h0064, 16'h0000, 3, 0, 0, 0, 5);
      @(negedge clk);

`ifdef DMEM_REQ_STATS_EN
      chk("stat_access", stat_access, 16'(m_acc));
      chk("stat_hit", stat_hit, 16'(m_hit));
      chk("stat_access_4", m_acc, 4);
`else
      chk("stat_access_off", stat_access, 16'h0000);
      chk("stat_hit_off", stat_hit, 16'h0000);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
